rcv_oversample_framer: RTL and testbench
========================================

Name: rcv_oversample_framer

Overview:
- Parametrised UART receive front end that replaces the fixed divide-by-16 baud counter and start-bit detector.
- Generates an oversample tick from Clock and validates the start bit by majority vote.
- Samples each data and stop bit at mid-bit using 3-sample majority, and flags framing, break and noise conditions.
- Feeds a downstream shift/holding register through a per-bit strobe; sits between the RxD pad and the receive data register.

Parameters:
- OVERSAMPLE, 16: oversample ticks per bit. Legal range 8..64. MID = OVERSAMPLE/2.
- PRESCALE, 1: Clock cycles per oversample tick. Legal range 1..65535.
- DATA_BITS, 8: data bits per frame. Legal range 5..9.
- STOP_BITS, 1: stop bits checked. Legal values 1 or 2.
- SYNC_STAGES, 2: RxD synchroniser flops. Legal range 2..4.

Ports:
- Clock  in  1  system clock, rising edge
- Reset  in  1  asynchronous, active-low reset
- Enable  in  1  receiver enable; low forces IDLE
- RxD  in  1  asynchronous serial line, idle high
- BaudClock  out  1  oversample counter MSB-equivalent: high while SubCnt >= MID
- StartDetect  out  1  1-cycle pulse on a validated start bit
- SampleValid  out  1  1-cycle pulse per data bit
- SampleBit  out  1  voted data bit value, valid with SampleValid
- BitIndex  out  4  index of the current data bit (0 = LSB first), valid with SampleValid
- FrameDone  out  1  1-cycle pulse after the last stop bit vote
- FramingError  out  1  1-cycle pulse, coincident with FrameDone, if any stop bit voted 0
- BreakDetect  out  1  1-cycle pulse with FramingError when all data bits were 0
- NoiseFlag  out  1  sticky; set if any vote in the frame was not unanimous; cleared on StartDetect
- Busy  out  1  high in every state except IDLE

Behaviour:
- Reset (Reset=0, async):
  - Synchroniser flops load 1.
  - State=IDLE; prescaler, SubCnt and BitIndex = 0.
  - All outputs 0.
- Synchroniser: rxs = RxD delayed SYNC_STAGES Clock cycles. All logic below uses rxs only.
- Prescaler: counts 0..PRESCALE-1, free-running. tick = (count == PRESCALE-1). With PRESCALE=1, tick is every cycle.
- SubCnt: advances only on tick, wraps OVERSAMPLE-1 -> 0. It is forced to 0 on entry to START.
- Vote: the samples taken at SubCnt = MID-1, MID and MID+1 form a 2-of-3 majority. The decision is made on the MID+1 tick.
- Pulse timing: all output pulses are registered and assert in the Clock cycle after the deciding tick, for exactly one cycle.
- States:
  - IDLE:
    - On tick, if rxs=0 and armed=1 -> START.
    - armed is cleared on a FramingError and set on the first tick that sees rxs=1, so a held-low line never retriggers.
  - START:
    - If the vote = 1 (false start) -> IDLE, with no pulse.
    - If the vote = 0 -> StartDetect pulse, NoiseFlag cleared, then updated from this vote.
    - On the SubCnt wrap -> DATA, BitIndex=0.
  - DATA:
    - On the vote -> SampleValid, SampleBit, BitIndex.
    - On the wrap: if BitIndex = DATA_BITS-1 -> STOP, else BitIndex+1.
  - STOP:
    - Vote on each stop bit. Any 0 latches a framing fault.
    - After the vote of the last stop bit -> FrameDone (+FramingError / +BreakDetect) and go to IDLE immediately. No wait for the wrap, so a back-to-back start edge is not missed.
- Bit period = OVERSAMPLE*PRESCALE Clock cycles. Any start edge is detected within one tick.
- Enable=0: synchronously forces IDLE, zeroes SubCnt and BitIndex, suppresses all pulses. A frame aborted mid-way produces no FrameDone. NoiseFlag holds its value.
- Simultaneous events: a vote and a wrap never coincide, because MID+1 < OVERSAMPLE. Enable=0 takes precedence over all transitions.

Test Plan:
- Defaults, Reset released, RxD idle 1 for 100 cycles -> all outputs 0, Busy 0, no StartDetect.
- Frame 0xA5 LSB first with 1 stop bit, bit period 16 cycles -> StartDetect once; 8 SampleValid at 16-cycle spacing with SampleBit = 1,0,1,0,0,1,0,1 and BitIndex 0..7; FrameDone 1 with FramingError 0; NoiseFlag 0.
- RxD low for 6 cycles then high -> no StartDetect, Busy returns to 0. A 1-tick low glitch at SubCnt=MID during bit 3 of 0xFF -> SampleBit=1, NoiseFlag=1.
- Stop bit held 0 with data 0x00, then line held low for 200 cycles -> FramingError=1, BreakDetect=1, and no new StartDetect until RxD returns to 1.
- PRESCALE=3, OVERSAMPLE=8, DATA_BITS=7, STOP_BITS=2, frame 0x55 with second stop bit 0 -> 7 SampleValid at 24-cycle spacing, FramingError=1.
- Enable dropped at DATA bit 4, then a full frame 0x3C sent after re-enable -> no FrameDone for the aborted frame; the second frame is received correctly. Async Reset asserted mid-frame -> outputs 0 immediately.

Source files
------------

// File: rtl/rcv_oversample_framer.sv
// UART receive front end: prescaled oversample timing, 3-sample majority voting of the
// start, data and stop bits, and per-bit strobes for a downstream holding register.
//
// state | meaning
// IDLE  | line idle; waiting for a low sample while armed
// START | validating the start bit by mid-bit vote
// DATA  | voting data bits, one SampleValid per bit
// STOP  | voting stop bits; FrameDone after the last one
module rcv_oversample_framer #(
  parameter int OVERSAMPLE  = 16,
  parameter int PRESCALE    = 1,
  parameter int DATA_BITS   = 8,
  parameter int STOP_BITS   = 1,
  parameter int SYNC_STAGES = 2
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       Enable,
  input  logic       RxD,
  output logic       BaudClock,
  output logic       StartDetect,
  output logic       SampleValid,
  output logic       SampleBit,
  output logic [3:0] BitIndex,
  output logic       FrameDone,
  output logic       FramingError,
  output logic       BreakDetect,
  output logic       NoiseFlag,
  output logic       Busy
);
  localparam int SW = $clog2(OVERSAMPLE);
  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [SW-1:0] SUB_LAST  = SW'(OVERSAMPLE - 1);
  localparam logic [SW-1:0] MID_LO    = SW'(OVERSAMPLE / 2 - 1);
  localparam logic [SW-1:0] MID       = SW'(OVERSAMPLE / 2);
  localparam logic [SW-1:0] MID_HI    = SW'(OVERSAMPLE / 2 + 1);
  localparam logic [PW-1:0] PRE_LAST  = PW'(PRESCALE - 1);
  localparam logic [3:0]    LAST_BIT  = 4'(DATA_BITS - 1);
  localparam logic          LAST_STOP = 1'(STOP_BITS - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t                 state;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   rxs;
  logic [PW-1:0]          pre_cnt;
  logic                   tick;
  logic [SW-1:0]          sub_cnt;
  logic                   armed;
  logic                   samp_lo;
  logic                   samp_mid;
  logic                   stop_idx;
  logic                   fe_seen;
  logic                   data_any;
  logic                   vote;
  logic                   unanimous;
  logic                   at_vote;
  logic                   at_wrap;
  logic                   frame_err;

  assign rxs       = sync_q[SYNC_STAGES-1];
  assign tick      = (pre_cnt == PRE_LAST);
  assign at_vote   = (sub_cnt == MID_HI);
  assign at_wrap   = (sub_cnt == SUB_LAST);
  // Third sample is the live synchronised line at the MID+1 tick.
  assign vote      = (samp_lo & samp_mid) | (samp_lo & rxs) | (samp_mid & rxs);
  assign unanimous = (samp_lo == samp_mid) && (samp_mid == rxs);
  assign frame_err = fe_seen | ~vote;
  assign BaudClock = (sub_cnt >= MID);
  assign Busy      = (state != IDLE);

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      sync_q  <= '1;
      pre_cnt <= '0;
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], RxD};
      pre_cnt <= tick ? '0 : pre_cnt + 1'b1;
    end
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state        <= IDLE;
      sub_cnt      <= '0;
      BitIndex     <= '0;
      stop_idx     <= 1'b0;
      armed        <= 1'b0;
      samp_lo      <= 1'b1;
      samp_mid     <= 1'b1;
      fe_seen      <= 1'b0;
      data_any     <= 1'b0;
      StartDetect  <= 1'b0;
      SampleValid  <= 1'b0;
      SampleBit    <= 1'b0;
      FrameDone    <= 1'b0;
      FramingError <= 1'b0;
      BreakDetect  <= 1'b0;
      NoiseFlag    <= 1'b0;
    end else begin
      StartDetect  <= 1'b0;
      SampleValid  <= 1'b0;
      FrameDone    <= 1'b0;
      FramingError <= 1'b0;
      BreakDetect  <= 1'b0;
      if (!Enable) begin
        state    <= IDLE;
        sub_cnt  <= '0;
        BitIndex <= '0;
      end else if (tick) begin
        if (state != IDLE) sub_cnt <= at_wrap ? '0 : sub_cnt + 1'b1;
        if (sub_cnt == MID_LO) samp_lo <= rxs;
        if (sub_cnt == MID) samp_mid <= rxs;
        case (state)
          IDLE: begin
            // A line held low after a framing fault must go high before re-arming.
            if (rxs) armed <= 1'b1;
            else if (armed) begin
              state   <= START;
              sub_cnt <= '0;
            end
          end
          START: begin
            if (at_vote) begin
              if (vote) begin
                state   <= IDLE;
                sub_cnt <= '0;
              end else begin
                StartDetect <= 1'b1;
                NoiseFlag   <= ~unanimous;
                fe_seen     <= 1'b0;
                data_any    <= 1'b0;
              end
            end else if (at_wrap) begin
              state    <= DATA;
              BitIndex <= '0;
            end
          end
          DATA: begin
            if (at_vote) begin
              SampleValid <= 1'b1;
              SampleBit   <= vote;
              data_any    <= data_any | vote;
              NoiseFlag   <= NoiseFlag | ~unanimous;
            end else if (at_wrap) begin
              if (BitIndex == LAST_BIT) begin
                state    <= STOP;
                stop_idx <= 1'b0;
              end else begin
                BitIndex <= BitIndex + 1'b1;
              end
            end
          end
          STOP: begin
            if (at_vote) begin
              NoiseFlag <= NoiseFlag | ~unanimous;
              // Return to IDLE right after the last vote so a back-to-back start is caught.
              if (stop_idx == LAST_STOP) begin
                FrameDone    <= 1'b1;
                FramingError <= frame_err;
                BreakDetect  <= frame_err & ~data_any;
                if (frame_err) armed <= 1'b0;
                state    <= IDLE;
                sub_cnt  <= '0;
                BitIndex <= '0;
              end else if (!vote) begin
                fe_seen <= 1'b1;
              end
            end else if (at_wrap) begin
              stop_idx <= stop_idx + 1'b1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_rcv_oversample_framer.sv
// Bench for rcv_oversample_framer: default instance plus a PRESCALE=3/OVERSAMPLE=8/
// DATA_BITS=7/STOP_BITS=2 instance, table vectors, corner sequences and random frames.
module tb_rcv_oversample_framer;
  logic       clk = 1'b0;
  logic       rst_n;
  logic       en    [2];
  logic       rxd   [2];
  logic       baud  [2];
  logic       sd    [2];
  logic       sv    [2];
  logic       sbit  [2];
  logic [3:0] bidx  [2];
  logic       fd    [2];
  logic       fe    [2];
  logic       brk   [2];
  logic       noise [2];
  logic       busy  [2];

  int     n_checks = 0;
  int     n_fail = 0;
  longint cyc = 0;
  int     n_start [2];
  int     n_sv    [2];
  int     n_done  [2];
  int     n_stray [2];
  int     n_baud  [2];
  logic   sv_bit   [2][1024];
  int     sv_idx   [2][1024];
  longint sv_cyc   [2][1024];
  logic   fd_fe    [2][128];
  logic   fd_brk   [2][128];
  logic   fd_noise [2][128];

  typedef struct {
    int         inst;
    logic [8:0] data;
    logic [1:0] stop;
    logic       exp_fe;
    logic       exp_brk;
  } vec_t;
  vec_t vecs [7];

  always #5 clk = ~clk;

  rcv_oversample_framer u_dut0 (
    .Clock(clk), .Reset(rst_n), .Enable(en[0]), .RxD(rxd[0]),
    .BaudClock(baud[0]), .StartDetect(sd[0]), .SampleValid(sv[0]), .SampleBit(sbit[0]),
    .BitIndex(bidx[0]), .FrameDone(fd[0]), .FramingError(fe[0]), .BreakDetect(brk[0]),
    .NoiseFlag(noise[0]), .Busy(busy[0])
  );

  rcv_oversample_framer #(
    .OVERSAMPLE(8), .PRESCALE(3), .DATA_BITS(7), .STOP_BITS(2), .SYNC_STAGES(2)
  ) u_dut1 (
    .Clock(clk), .Reset(rst_n), .Enable(en[1]), .RxD(rxd[1]),
    .BaudClock(baud[1]), .StartDetect(sd[1]), .SampleValid(sv[1]), .SampleBit(sbit[1]),
    .BitIndex(bidx[1]), .FrameDone(fd[1]), .FramingError(fe[1]), .BreakDetect(brk[1]),
    .NoiseFlag(noise[1]), .Busy(busy[1])
  );

  function automatic int ov_of(input int i);   return (i == 0) ? 16 : 8; endfunction
  function automatic int pre_of(input int i);  return (i == 0) ? 1 : 3;  endfunction
  function automatic int db_of(input int i);   return (i == 0) ? 8 : 7;  endfunction
  function automatic int ns_of(input int i);   return (i == 0) ? 1 : 2;  endfunction
  function automatic int per_of(input int i);  return ov_of(i) * pre_of(i); endfunction
  function automatic logic [8:0] mask_of(input int i); return (i == 0) ? 9'h0FF : 9'h07F; endfunction

  // Cycles with SubCnt >= MID in one frame: every full bit contributes OV/2 ticks,
  // the last stop bit only MID and MID+1 before the immediate return to IDLE.
  function automatic int baud_exp(input int i);
    return ((db_of(i) + ns_of(i)) * (ov_of(i) / 2) + 2) * pre_of(i);
  endfunction

  function automatic logic [1:0] ref_flags(input int i, input logic [8:0] data, input logic [1:0] stop);
    logic stop_low;
    stop_low = (stop[0] == 1'b0) || (ns_of(i) == 2 && stop[1] == 1'b0);
    return {stop_low, stop_low && ((data & mask_of(i)) == 9'h000)};
  endfunction

  function automatic logic [12:0] out_vec(input int i);
    return {baud[i], sd[i], sv[i], sbit[i], bidx[i], fd[i], fe[i], brk[i], noise[i], busy[i]};
  endfunction

  always @(negedge clk) begin
    cyc = cyc + 1;
    for (int i = 0; i < 2; i++) begin
      if (sd[i]) n_start[i]++;
      if (baud[i]) n_baud[i]++;
      if ((fe[i] || brk[i]) && !fd[i]) n_stray[i]++;
      if (sv[i] && n_sv[i] < 1024) begin
        sv_bit[i][n_sv[i]] = sbit[i];
        sv_idx[i][n_sv[i]] = int'(bidx[i]);
        sv_cyc[i][n_sv[i]] = cyc;
        n_sv[i]++;
      end
      if (fd[i] && n_done[i] < 128) begin
        fd_fe[i][n_done[i]]    = fe[i];
        fd_brk[i][n_done[i]]   = brk[i];
        fd_noise[i][n_done[i]] = noise[i];
        n_done[i]++;
      end
    end
  end

  task automatic chk(input string nm, input longint got, input longint exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s got=%0d expected=%0d", nm, got, exp);
    end
  endtask

  task automatic hold(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input int i, input logic [8:0] data, input logic [1:0] stop,
                            input int gbit, input int goff);
    int p;
    p = per_of(i);
    rxd[i] = 1'b0;
    hold(p);
    for (int b = 0; b < db_of(i); b++) begin
      rxd[i] = data[b];
      if (b == gbit) begin
        hold(goff);
        rxd[i] = ~data[b];
        hold(1);
        rxd[i] = data[b];
        hold(p - goff - 1);
      end else begin
        hold(p);
      end
    end
    for (int s = 0; s < ns_of(i); s++) begin
      rxd[i] = stop[s];
      hold(p);
    end
  endtask

  task automatic run_frame(input int i, input logic [8:0] data, input logic [1:0] stop,
                           input int gbit, input int goff,
                           input logic exp_fe, input logic exp_brk, input logic exp_noise);
    int s0, v0, d0, b0, nbits, bad_idx, bad_gap;
    logic [8:0] got;
    s0 = n_start[i]; v0 = n_sv[i]; d0 = n_done[i]; b0 = n_baud[i];
    send_frame(i, data, stop, gbit, goff);
    rxd[i] = 1'b1;
    hold(per_of(i));
    got = '0; bad_idx = 0; bad_gap = 0;
    nbits = n_sv[i] - v0;
    if (nbits > db_of(i)) nbits = db_of(i);
    for (int k = 0; k < nbits; k++) begin
      got[k] = sv_bit[i][v0+k];
      if (sv_idx[i][v0+k] != k) bad_idx++;
      if (k > 0 && (sv_cyc[i][v0+k] - sv_cyc[i][v0+k-1]) != longint'(per_of(i))) bad_gap++;
    end
    chk($sformatf("i%0d_d%02h_start_pulses", i, data), n_start[i] - s0, 1);
    chk($sformatf("i%0d_d%02h_sample_pulses", i, data), n_sv[i] - v0, db_of(i));
    chk($sformatf("i%0d_d%02h_data", i, data), got, data);
    chk($sformatf("i%0d_d%02h_bit_index_errs", i, data), bad_idx, 0);
    chk($sformatf("i%0d_d%02h_bit_spacing_errs", i, data), bad_gap, 0);
    chk($sformatf("i%0d_d%02h_baud_cycles", i, data), n_baud[i] - b0, baud_exp(i));
    chk($sformatf("i%0d_d%02h_frame_done", i, data), n_done[i] - d0, 1);
    if (n_done[i] > d0) begin
      chk($sformatf("i%0d_d%02h_framing_err", i, data), fd_fe[i][d0], exp_fe);
      chk($sformatf("i%0d_d%02h_break", i, data), fd_brk[i][d0], exp_brk);
      chk($sformatf("i%0d_d%02h_noise", i, data), fd_noise[i][d0], exp_noise);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout checks=%0d", n_checks);
    $fatal(1);
  end

  initial begin
    logic [25:0] acc;
    logic [8:0]  rdata;
    logic [1:0]  rstop;
    logic [1:0]  flags;
    int          s0, v0, d0, ri;

    rst_n = 1'b1; en[0] = 1'b1; en[1] = 1'b1; rxd[0] = 1'b1; rxd[1] = 1'b1;
    #2 rst_n = 1'b0;
    hold(3);
    rst_n = 1'b1;

    acc = '0;
    repeat (100) begin
      @(negedge clk);
      acc = acc | {out_vec(0), out_vec(1)};
    end
    hold(1);
    chk("idle_outputs", acc, 0);
    chk("idle_start_pulses", n_start[0] + n_start[1], 0);

    vecs[0] = '{0, 9'h0A5, 2'b11, 1'b0, 1'b0};
    vecs[1] = '{0, 9'h000, 2'b11, 1'b0, 1'b0};
    vecs[2] = '{0, 9'h0FF, 2'b10, 1'b1, 1'b0};
    vecs[3] = '{1, 9'h055, 2'b01, 1'b1, 1'b0};
    vecs[4] = '{1, 9'h000, 2'b10, 1'b1, 1'b1};
    vecs[5] = '{1, 9'h07F, 2'b11, 1'b0, 1'b0};
    vecs[6] = '{0, 9'h001, 2'b11, 1'b0, 1'b0};
    for (int k = 0; k < 7; k++)
      run_frame(vecs[k].inst, vecs[k].data, vecs[k].stop, -1, 0, vecs[k].exp_fe, vecs[k].exp_brk, 1'b0);

    // Short low pulse: START entered, but the mid-bit vote rejects it.
    s0 = n_start[0];
    rxd[0] = 1'b0;
    hold(6);
    chk("false_start_busy_high", busy[0], 1);
    rxd[0] = 1'b1;
    hold(40);
    chk("false_start_pulses", n_start[0] - s0, 0);
    chk("false_start_busy_low", busy[0], 0);

    // One-cycle glitch at the MID sample of data bit 3.
    run_frame(0, 9'h0FF, 2'b11, 3, 9, 1'b0, 1'b0, 1'b1);

    // Break frame followed by a line held low.
    s0 = n_start[0]; d0 = n_done[0];
    send_frame(0, 9'h000, 2'b00, -1, 0);
    rxd[0] = 1'b0;
    hold(200);
    chk("break_start_pulses", n_start[0] - s0, 1);
    chk("break_frame_done", n_done[0] - d0, 1);
    if (n_done[0] > d0) begin
      chk("break_framing_err", fd_fe[0][d0], 1);
      chk("break_flag", fd_brk[0][d0], 1);
    end
    rxd[0] = 1'b1;
    hold(16);
    chk("break_no_retrigger", n_start[0] - s0, 1);
    run_frame(0, 9'h05A, 2'b11, -1, 0, 1'b0, 1'b0, 1'b0);

    // Enable dropped inside data bit 4 of 0x96.
    s0 = n_start[0]; v0 = n_sv[0]; d0 = n_done[0];
    rxd[0] = 1'b0;
    hold(16);
    for (int b = 0; b < 4; b++) begin
      rxd[0] = (b == 1 || b == 2);
      hold(16);
    end
    rxd[0] = 1'b1;
    hold(8);
    en[0] = 1'b0;
    hold(2);
    chk("disable_busy", busy[0], 0);
    hold(40);
    en[0] = 1'b1;
    hold(16);
    chk("abort_start_pulses", n_start[0] - s0, 1);
    chk("abort_sample_pulses", n_sv[0] - v0, 4);
    chk("abort_no_frame_done", n_done[0] - d0, 0);
    run_frame(0, 9'h03C, 2'b11, -1, 0, 1'b0, 1'b0, 1'b0);

    for (int r = 0; r < 24; r++) begin
      ri = r % 2;
      rdata = 9'($urandom) & mask_of(ri);
      if ($urandom_range(0, 5) == 0) rdata = 9'h000;
      rstop = 2'b11;
      if ($urandom_range(0, 3) == 0) rstop[$urandom_range(0, ns_of(ri) - 1)] = 1'b0;
      flags = ref_flags(ri, rdata, rstop);
      run_frame(ri, rdata, rstop, -1, 0, flags[1], flags[0], 1'b0);
    end

    // Async reset in the middle of a frame.
    rxd[0] = 1'b0;
    hold(16);
    rxd[0] = 1'b1;
    hold(30);
    chk("reset_busy_before", busy[0], 1);
    #2 rst_n = 1'b0;
    #1;
    chk("reset_outputs_async_i0", out_vec(0), 0);
    chk("reset_outputs_async_i1", out_vec(1), 0);
    hold(3);
    rst_n = 1'b1;
    hold(50);
    run_frame(0, 9'h0C3, 2'b11, -1, 0, 1'b0, 1'b0, 1'b0);

    chk("stray_flags_i0", n_stray[0], 0);
    chk("stray_flags_i1", n_stray[1], 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
